// File: rtl/framebuffer_pkg.sv
// Shared types and constants for the framebuffer PSRAM line fetch engine.
package framebuffer_pkg;

  localparam int DEF_ADDR_W       = 21;
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_PIXEL_W      = 16;
  localparam int DEF_BURST_PIXELS = 32;
  localparam int DEF_LINE_W       = 11;
  localparam int DEF_BANK_ADDR_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  function automatic int calc_beats(input int burst_pixels, input int pixel_w, input int data_w);
    return (burst_pixels * pixel_w) / data_w;
  endfunction

endpackage

// File: rtl/framebuffer_fetch_window.sv
// Vertical window tracking: line/repeat counters, shadowed base/stride and the
// per-line fetch decision.
module framebuffer_fetch_window
  import framebuffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [LINE_W-1:0] reg_width,
  input  logic [LINE_W-1:0] reg_start_line,
  input  logic [LINE_W-1:0] reg_end_line,
  input  logic [ADDR_W-1:0] reg_base_addr,
  input  logic [ADDR_W-1:0] reg_stride,
  input  logic [1:0]        reg_vrep,
  output logic              fetch_now,
  output logic [ADDR_W-1:0] fetch_addr
);

  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] cur_line;
  logic [2:0]        rep_cnt;
  logic [2:0]        cur_rep;
  logic [2:0]        rep_mask;
  logic [2:0]        rep_nxt;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] stride_s;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] cur_stride;
  logic              in_window;

  // A frame start in the same cycle as a line start takes effect first.
  always_comb begin
    cur_line   = frame_start ? '0 : line_cnt;
    cur_rep    = frame_start ? 3'd0 : rep_cnt;
    cur_addr   = frame_start ? reg_base_addr : line_addr;
    cur_stride = frame_start ? reg_stride : stride_s;
    rep_mask   = 3'((4'd1 << reg_vrep) - 4'd1);
    rep_nxt    = (cur_rep + 3'd1) & rep_mask;
    in_window  = (cur_line >= reg_start_line) && (cur_line < reg_end_line);
    fetch_now  = line_start && in_window && (cur_rep == 3'd0) && (reg_width != '0);
    fetch_addr = cur_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_cnt  <= '0;
      rep_cnt   <= 3'd0;
      line_addr <= '0;
      stride_s  <= '0;
    end else begin
      if (frame_start) begin
        line_cnt  <= '0;
        rep_cnt   <= 3'd0;
        line_addr <= reg_base_addr;
        stride_s  <= reg_stride;
      end
      if (line_start) begin
        line_cnt <= cur_line + LINE_W'(1);
        if (in_window) begin
          rep_cnt <= rep_nxt;
          if (rep_nxt == 3'd0) line_addr <= cur_addr + cur_stride;
        end
      end
    end
  end

endmodule

// File: rtl/framebuffer_line_fetch.sv
// PSRAM line fetch engine: bursts one source line per fetch into a ping-pong
// line buffer and steers the video side to the last completed bank.
//
// state | meaning
// IDLE  | no burst outstanding
// REQ   | requesting a burst from the arbiter
// DATA  | writing the beats of the granted burst
// DRAIN | discarding the rest of an aborted burst
module framebuffer_line_fetch
  import framebuffer_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PIXEL_W      = DEF_PIXEL_W,
  parameter int BURST_PIXELS = DEF_BURST_PIXELS,
  parameter int LINE_W       = DEF_LINE_W,
  parameter int BANK_ADDR_W  = DEF_BANK_ADDR_W
) (
  input  logic                   i_psram_clk,
  input  logic                   i_psram_rst_n,
  input  logic [LINE_W-1:0]      i_reg_width,
  input  logic [LINE_W-1:0]      i_reg_start_line,
  input  logic [LINE_W-1:0]      i_reg_end_line,
  input  logic [ADDR_W-1:0]      i_reg_base_addr,
  input  logic [ADDR_W-1:0]      i_reg_stride,
  input  logic [1:0]             i_reg_vrep,
  input  logic                   i_frame_start,
  input  logic                   i_line_start,
  output logic                   o_psram_req,
  input  logic                   i_psram_gnt,
  output logic [ADDR_W-1:0]      o_psram_addr,
  input  logic [DATA_W-1:0]      i_psram_data,
  input  logic                   i_psram_data_valid,
  output logic                   o_lb_wr_en,
  output logic [BANK_ADDR_W:0]   o_lb_wr_addr,
  output logic [DATA_W-1:0]      o_lb_wr_data,
  output logic                   o_lb_rd_bank,
  output logic                   o_busy,
  output logic                   o_underrun
);

  localparam int BEATS  = calc_beats(BURST_PIXELS, PIXEL_W, DATA_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PX_W   = LINE_W + 1;

  fetch_state_t           state;
  logic [PX_W-1:0]        px_cnt;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [BANK_ADDR_W-1:0] wr_word;
  logic [ADDR_W-1:0]      fetch_base;
  logic                   wr_bank;
  logic                   last_fill_bank;
  logic                   fetched;
  logic                   pending;

  logic                   fetch_now;
  logic [ADDR_W-1:0]      fetch_addr;
  logic                   restart;
  logic                   beat_last;
  logic                   pend_n;
  logic [ADDR_W-1:0]      drain_addr;

  framebuffer_fetch_window #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_window (
    .clk            (i_psram_clk),
    .rst_n          (i_psram_rst_n),
    .frame_start    (i_frame_start),
    .line_start     (i_line_start),
    .reg_width      (i_reg_width),
    .reg_start_line (i_reg_start_line),
    .reg_end_line   (i_reg_end_line),
    .reg_base_addr  (i_reg_base_addr),
    .reg_stride     (i_reg_stride),
    .reg_vrep       (i_reg_vrep),
    .fetch_now      (fetch_now),
    .fetch_addr     (fetch_addr)
  );

  always_comb begin
    restart    = i_frame_start | i_line_start;
    beat_last  = i_psram_data_valid && (beat_cnt == BEAT_W'(BEATS - 1));
    pend_n     = i_frame_start ? fetch_now : (pending | fetch_now);
    drain_addr = fetch_now ? fetch_addr : fetch_base;
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_psram_clk) begin
    if (!i_psram_rst_n) begin
      state          <= IDLE;
      o_psram_req    <= 1'b0;
      o_psram_addr   <= '0;
      o_lb_wr_en     <= 1'b0;
      o_lb_wr_addr   <= '0;
      o_lb_wr_data   <= '0;
      o_lb_rd_bank   <= 1'b0;
      o_underrun     <= 1'b0;
      px_cnt         <= '0;
      beat_cnt       <= '0;
      wr_word        <= '0;
      fetch_base     <= '0;
      wr_bank        <= 1'b0;
      last_fill_bank <= 1'b0;
      fetched        <= 1'b0;
      pending        <= 1'b0;
    end else begin
      o_lb_wr_en <= 1'b0;

      if (i_frame_start) o_underrun <= 1'b0;
      else if (i_line_start && (state == REQ || state == DATA)) o_underrun <= 1'b1;

      if (i_line_start) begin
        if (fetched) o_lb_rd_bank <= last_fill_bank;
        fetched <= fetch_now;
      end

      if (fetch_now) begin
        wr_bank        <= ~wr_bank;
        last_fill_bank <= ~wr_bank;
        px_cnt         <= '0;
        wr_word        <= '0;
        fetch_base     <= fetch_addr;
      end

      case (state)
        IDLE: begin
          if (fetch_now) begin
            state        <= REQ;
            o_psram_req  <= 1'b1;
            o_psram_addr <= fetch_addr;
          end
        end
        REQ: begin
          if (i_psram_gnt) begin
            o_psram_req <= 1'b0;
            beat_cnt    <= '0;
            // A granted burst must still be absorbed even if the line is abandoned.
            if (restart) begin
              state   <= DRAIN;
              pending <= fetch_now;
            end else begin
              state  <= DATA;
              px_cnt <= px_cnt + PX_W'(BURST_PIXELS);
            end
          end else if (restart) begin
            pending <= 1'b0;
            if (fetch_now) begin
              o_psram_addr <= fetch_addr;
            end else begin
              state       <= IDLE;
              o_psram_req <= 1'b0;
            end
          end
        end
        DATA: begin
          if (restart) begin
            if (beat_last) begin
              pending <= 1'b0;
              if (fetch_now) begin
                state        <= REQ;
                o_psram_req  <= 1'b1;
                o_psram_addr <= fetch_addr;
              end else begin
                state <= IDLE;
              end
            end else begin
              state    <= DRAIN;
              pending  <= fetch_now;
              beat_cnt <= beat_cnt + BEAT_W'(i_psram_data_valid);
            end
          end else if (i_psram_data_valid) begin
            o_lb_wr_en   <= 1'b1;
            o_lb_wr_addr <= {wr_bank, wr_word};
            o_lb_wr_data <= i_psram_data;
            wr_word      <= wr_word + BANK_ADDR_W'(1);
            beat_cnt     <= beat_cnt + BEAT_W'(1);
            if (beat_last) begin
              if (px_cnt >= {1'b0, i_reg_width}) begin
                state <= IDLE;
              end else begin
                state        <= REQ;
                o_psram_req  <= 1'b1;
                o_psram_addr <= fetch_base + ADDR_W'(px_cnt);
              end
            end
          end
        end
        DRAIN: begin
          pending <= pend_n;
          if (beat_last) begin
            pending      <= 1'b0;
            state        <= pend_n ? REQ : IDLE;
            o_psram_req  <= pend_n;
            o_psram_addr <= drain_addr;
          end else if (i_psram_data_valid) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/framebuffer_line_fetch.md
# framebuffer_line_fetch

Parametrised PSRAM-side line fetch engine for the framebuffer read path, the next generation of the existing line reader. On each line-start pulse inside the programmed vertical window, it fetches one source line from PSRAM in fixed bursts into a ping-pong line buffer, and tells the video side which bank to read. It adds a programmable frame base address and line stride, vertical line repeat (1/2/4/8×), underrun detection and abort/drain. It sits between the PSRAM arbiter (req/gnt) and the external dual-port line buffer. Hsync/vsync edge synchronisation happens upstream.

## Interface
- ADDR_W, 21, PSRAM address width; unit = one pixel
- DATA_W, 64, PSRAM data beat width
- PIXEL_W, 16, bits per pixel
- BURST_PIXELS, 32, pixels per PSRAM burst; BEATS = BURST_PIXELS*PIXEL_W/DATA_W (8 at defaults)
- LINE_W, 11, width of width/line registers
- BANK_ADDR_W, 9, line-buffer word address bits per bank
- i_psram_clk  in  1  only clock
- i_psram_rst_n  in  1  synchronous, active-low reset
- i_reg_width  in  LINE_W  active pixels per line; multiple of BURST_PIXELS; 0 = no fetch
- i_reg_start_line / i_reg_end_line  in  LINE_W  window is start ≤ L < end
- i_reg_base_addr  in  ADDR_W  frame base; shadowed at frame start
- i_reg_stride  in  ADDR_W  pixels between source lines; shadowed at frame start
- i_reg_vrep  in  2  line repeat = 2^vrep
- i_frame_start  in  1  one-cycle pulse (synchronised vsync edge)
- i_line_start  in  1  one-cycle pulse (synchronised hsync edge)
- o_psram_req  out  1  burst request
- i_psram_gnt  in  1  one-cycle grant
- o_psram_addr  out  ADDR_W  burst start address
- i_psram_data  in  DATA_W  read beat
- i_psram_data_valid  in  1  beat strobe
- o_lb_wr_en  out  1  line-buffer write
- o_lb_wr_addr  out  BANK_ADDR_W+1  {bank, word}
- o_lb_wr_data  out  DATA_W  registered beat
- o_lb_rd_bank  out  1  bank the video side reads this line
- o_busy  out  1  state ≠ IDLE
- o_underrun  out  1  sticky; cleared by frame start

## Operation
- Frame start:
  - line_cnt←0, rep_cnt←0, line_addr←base, stride_s←stride, underrun←0.
  - If a fetch is in progress, abort to DRAIN and drop any pending line.
- Line start, with L = line_cnt:
  - fetch_now = (start ≤ L < end) & (rep_cnt==0) & (width≠0).
  - Then line_cnt←L+1.
  - While in the window, rep_cnt increments mod 2^vrep. When it wraps, line_addr += stride_s (mod 2^ADDR_W).
  - o_lb_rd_bank←last_fill_bank whenever a fetch has started since the previous line start.
  - On fetch_now: wr_bank toggles, last_fill_bank←new wr_bank, px_cnt←0.
- States:
  - IDLE: fetch_now → REQ.
  - REQ: o_psram_req=1, o_psram_addr=line_addr+px_cnt. On gnt: px_cnt += BURST_PIXELS, → DATA.
  - DATA: count BEATS valid beats. After the last beat: px_cnt ≥ width → IDLE, else → REQ.
  - DRAIN: writes suppressed; absorb the remaining beats of the granted burst. Then → REQ if a line is pending, else IDLE.
- Line start while in REQ or DATA:
  - o_underrun←1.
  - Bank and counter updates happen normally; the new line is marked pending.
  - REQ aborts straight to the new line (req stays high, address reloads).
  - DATA → DRAIN.
- Line-buffer word address resets to 0 per fetch and increments per written beat. Its MSB is wr_bank.
- Simultaneous frame_start & line_start: the frame-start actions apply first, then the line start is evaluated with L=0; line_cnt ends at 1.

## Timing
- Reset values: o_psram_req 0, o_psram_addr 0, o_lb_wr_en 0, o_lb_wr_addr 0, o_lb_wr_data 0, o_lb_rd_bank 0, o_busy 0, o_underrun 0. Internal state: wr_bank 0, state IDLE.
- line_start at cycle t → o_psram_req=1 at t+1.
- gnt at t → req=0 at t+1, unless the line needs another burst, in which case req re-asserts after the last beat.
- data_valid at t → o_lb_wr_en/addr/data at t+1 (one register stage).
- o_lb_rd_bank changes at t+1 after line_start.
- Reset asserted mid-burst discards all state. The bench must not deliver stale beats after reset.

## Structure
- Package framebuffer_pkg: state encoding (IDLE/REQ/DATA/DRAIN), BEATS derivation, default parameter constants.
- Sub-module framebuffer_fetch_window: line_cnt, rep_cnt, line_addr, shadow registers, fetch_now generation.
- Top level: state machine, px/beat counters, banking.
- Line-buffer RAM is external.

## Test plan
- Defaults; base 0, stride 640, width 640, window 0–480, vrep 0 → line 0 issues 20 bursts at addresses 0,32,…,608 and 160 writes to bank 1. Line 1 sets rd_bank=1 and fetches from address 640.
- vrep=1 → fetch starts on lines 0,2,4 only, with addresses 0, 640, 1280. rd_bank holds the same bank across each line pair.
- start=10, end=12 → fetches on lines 10 and 11 only. Lines 0–9 and 12+ leave req low.
- Arbiter withholds gnt so that line_start arrives mid-DATA → underrun=1, no writes during DRAIN, the next line starts fetching at the new address, and frame_start clears underrun.
- frame_start and line_start in the same cycle, with base changed to 0x10000 → line_cnt=1 and the first burst address is 0x10000.
- Reset pulsed during DATA → all outputs return to reset values on the next cycle and the next line fetches cleanly.
